// File: rtl/store_buffer_pkg.sv
// Shared memory-path types for the store buffer, data memory and MEM stage.
package mips_mem_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_IDX_W = 10;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } sb_entry_t;

    // Word index used to decide whether two byte addresses hit the same word.
    function automatic logic [SB_IDX_W-1:0] word_idx(input logic [31:0] addr);
        return addr[SB_IDX_W+1:2];
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store, load-forward and data-memory drain signals of the store buffer.
interface store_buffer_if;

    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic        st_ready;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        dm_grant;
    logic        dm_memwrite;
    logic [31:0] dm_addr;
    logic [31:0] dm_invalue;
    logic [31:0] dm_pc;
    logic        empty;
    logic        full;

    modport master (
        output st_valid, st_addr, st_data, st_pc, ld_addr, dm_grant,
        input  st_ready, ld_hit, ld_data, dm_memwrite, dm_addr, dm_invalue, dm_pc,
               empty, full
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_pc, ld_addr, dm_grant,
        output st_ready, ld_hit, ld_data, dm_memwrite, dm_addr, dm_invalue, dm_pc,
               empty, full
    );

endinterface

// File: rtl/store_buffer_fwd_match.sv
// Load-forwarding match: scans valid entries youngest-first (from tail-1) and
// returns the data of the first word-index match.
module sb_fwd_match
    import mips_mem_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH,
    parameter  int IDX_W = SB_IDX_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  sb_entry_t        entries [DEPTH],
    input  logic [PTR_W-1:0] head,
    input  logic [CNT_W-1:0] count,
    input  logic [IDX_W-1:0] ld_idx,
    output logic             hit,
    output logic [31:0]      data
);

    logic [PTR_W-1:0] slot;

    // NOTE: every variable driven here gets a default before the loop, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        slot = '0;
        for (int k = 0; k < DEPTH; k++) begin
            // k = 0 is the youngest entry (tail-1); pointer arithmetic wraps mod DEPTH.
            slot = head + PTR_W'(count) - PTR_W'(k + 1);
            if (!hit && (CNT_W'(k) < count) &&
                (entries[slot].addr[IDX_W+1:2] == ld_idx)) begin
                hit  = 1'b1;
                data = entries[slot].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order word store buffer: absorbs CPU stores, drains one per granted cycle
// to data memory, and forwards buffered data to younger loads.
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int IDX_W = SB_IDX_W
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic is_full;
    logic is_empty;
    logic enq;
    logic drain;

    assign is_full  = (count == CNT_W'(DEPTH));
    assign is_empty = (count == '0);
    // A slot freed by this cycle's drain only becomes usable next cycle.
    assign enq      = bus.st_valid && !is_full;
    assign drain    = !is_empty && bus.dm_grant;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)   tail <= tail + PTR_W'(1);
            if (drain) head <= head + PTR_W'(1);
            unique case ({enq, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the entry array has no reset; count alone decides which entries
    // are live, so stale contents after reset are never observed.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries[tail] <= '{addr: bus.st_addr, data: bus.st_data, pc: bus.st_pc};
        end
    end

    sb_fwd_match #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_fwd (
        .entries (entries),
        .head    (head),
        .count   (count),
        .ld_idx  (bus.ld_addr[IDX_W+1:2]),
        .hit     (bus.ld_hit),
        .data    (bus.ld_data)
    );

    always_comb begin
        bus.dm_addr    = '0;
        bus.dm_invalue = '0;
        bus.dm_pc      = '0;
        if (!is_empty) begin
            bus.dm_addr    = entries[head].addr;
            bus.dm_invalue = entries[head].data;
            bus.dm_pc      = entries[head].pc;
        end
    end

    assign bus.dm_memwrite = drain;
    assign bus.st_ready    = !is_full;
    assign bus.empty       = is_empty;
    assign bus.full        = is_full;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue model of pending stores serves
// as scoreboard for dm drains, occupancy flags and load forwarding.
module tb_store_buffer;
    import mips_mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    store_buffer_if bus ();

    store_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int        checks   = 0;
    int        failures = 0;
    int        drained  = 0;
    bit        mon_en   = 1'b0;
    bit        do_pop;
    sb_entry_t sb_q[$];
    logic [31:0] pc_ctr = 32'h0040_0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected view of the buffer, derived from the pending-store queue.
    always @(negedge clk) begin
        if (mon_en) begin
            logic        exp_hit;
            logic [31:0] exp_data;
            exp_hit  = 1'b0;
            exp_data = '0;
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (!exp_hit && word_idx(sb_q[i].addr) == word_idx(bus.ld_addr)) begin
                    exp_hit  = 1'b1;
                    exp_data = sb_q[i].data;
                end
            end
            do_pop = (sb_q.size() > 0) && bus.dm_grant;
            check("mon_empty", 32'(bus.empty), 32'(sb_q.size() == 0));
            check("mon_full", 32'(bus.full), 32'(sb_q.size() == 4));
            check("mon_st_ready", 32'(bus.st_ready), 32'(sb_q.size() < 4));
            check("mon_memwrite", 32'(bus.dm_memwrite), 32'(do_pop));
            check("mon_ld_hit", 32'(bus.ld_hit), 32'(exp_hit));
            check("mon_ld_data", bus.ld_data, exp_data);
            if (sb_q.size() > 0) begin
                check("sb_addr", bus.dm_addr, sb_q[0].addr);
                check("sb_data", bus.dm_invalue, sb_q[0].data);
                check("sb_pc", bus.dm_pc, sb_q[0].pc);
            end else begin
                check("idle_dm_addr", bus.dm_addr, 32'h0);
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            sb_q.delete();
        end else if (mon_en) begin
            bit push;
            push = bus.st_valid && (sb_q.size() < 4);
            if (do_pop) begin
                void'(sb_q.pop_front());
                drained++;
            end
            if (push) sb_q.push_back('{addr: bus.st_addr, data: bus.st_data, pc: bus.st_pc});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents a store and holds it until accepted; optionally toggles grant each cycle.
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input bit tog);
        bit acc;
        acc = 1'b0;
        bus.st_valid = 1'b1;
        bus.st_addr  = addr;
        bus.st_data  = data;
        bus.st_pc    = pc_ctr;
        pc_ctr       = pc_ctr + 32'd4;
        for (int t = 0; t < 100 && !acc; t++) begin
            if (tog) bus.dm_grant = !bus.dm_grant;
            @(negedge clk);
            acc = bus.st_ready;
            cyc();
        end
        if (!acc) check("store_timeout", 32'(acc), 32'd1);
        bus.st_valid = 1'b0;
    endtask

    task automatic drain_all();
        bus.dm_grant = 1'b1;
        for (int t = 0; t < 100 && !bus.empty; t++) cyc();
        check("drain_empty", 32'(bus.empty), 32'd1);
    endtask

    initial begin
        int start;
        reset        = 1'b1;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_pc    = '0;
        bus.ld_addr  = 32'hFFFF_FFF0;
        bus.dm_grant = 1'b0;
        cyc();
        cyc();
        reset  = 1'b0;
        mon_en = 1'b1;

        // 1: reset state
        @(negedge clk);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_st_ready", 32'(bus.st_ready), 32'd1);
        check("rst_memwrite", 32'(bus.dm_memwrite), 32'd0);
        check("rst_ld_hit", 32'(bus.ld_hit), 32'd0);
        check("rst_ld_data", bus.ld_data, 32'd0);
        check("rst_dm_addr", bus.dm_addr, 32'd0);
        cyc();

        // 2: single store drains the following cycle
        bus.dm_grant = 1'b1;
        do_store(32'h10, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        check("t2_memwrite", 32'(bus.dm_memwrite), 32'd1);
        check("t2_dm_addr", bus.dm_addr, 32'h10);
        check("t2_dm_invalue", bus.dm_invalue, 32'hDEAD_BEEF);
        cyc();
        @(negedge clk);
        check("t2_empty", 32'(bus.empty), 32'd1);
        cyc();

        // 3: fill, stall a 5th store, single-cycle grant frees one slot
        bus.dm_grant = 1'b0;
        for (int i = 0; i < 4; i++) do_store(32'(i * 4), 32'h100 + 32'(i), 1'b0);
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'h30;
        bus.st_data  = 32'h555;
        bus.st_pc    = pc_ctr;
        pc_ctr       = pc_ctr + 32'd4;
        @(negedge clk);
        check("t3_full", 32'(bus.full), 32'd1);
        check("t3_st_ready", 32'(bus.st_ready), 32'd0);
        cyc();
        bus.dm_grant = 1'b1;
        @(negedge clk);
        check("t3_drain_addr", bus.dm_addr, 32'h0);
        check("t3_drain_we", 32'(bus.dm_memwrite), 32'd1);
        check("t3_still_stall", 32'(bus.st_ready), 32'd0);
        cyc();
        bus.dm_grant = 1'b0;
        @(negedge clk);
        check("t3_ready_after", 32'(bus.st_ready), 32'd1);
        cyc();
        bus.st_valid = 1'b0;
        drain_all();
        cyc();

        // 4: forwarding picks the youngest match
        bus.dm_grant = 1'b0;
        do_store(32'h20, 32'd1, 1'b0);
        do_store(32'h20, 32'd2, 1'b0);
        bus.ld_addr = 32'h22;
        @(negedge clk);
        check("t4_hit", 32'(bus.ld_hit), 32'd1);
        check("t4_data", bus.ld_data, 32'd2);
        bus.ld_addr = 32'h24;
        @(negedge clk);
        check("t4_miss_hit", 32'(bus.ld_hit), 32'd0);
        check("t4_miss_data", bus.ld_data, 32'd0);
        bus.ld_addr = 32'h20;
        cyc();
        drain_all();
        cyc();

        // 5: wrap-around with toggling grant; scoreboard checks order and pc
        bus.dm_grant = 1'b0;
        start = drained;
        for (int i = 0; i < 10; i++) do_store(32'h200 + 32'(i * 4), 32'hA000 + 32'(i), 1'b1);
        drain_all();
        cyc();
        check("t5_drained", 32'(drained - start), 32'd10);
        check("t5_sb_left", 32'(sb_q.size()), 32'd0);

        // 6: reset discards pending stores
        bus.dm_grant = 1'b0;
        do_store(32'h40, 32'h1, 1'b0);
        do_store(32'h44, 32'h2, 1'b0);
        do_store(32'h48, 32'h3, 1'b0);
        bus.ld_addr = 32'h40;
        @(negedge clk);
        check("t6_pre_hit", 32'(bus.ld_hit), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus.dm_grant = 1'b1;
        @(negedge clk);
        check("t6_empty", 32'(bus.empty), 32'd1);
        check("t6_ld_hit", 32'(bus.ld_hit), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_write", 32'(bus.dm_memwrite), 32'd0);
            cyc();
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
